// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: FSM state encodings and width helpers shared by the UART TX arbiter.
package uart_arb_pkg;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_START     = 2'd1;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   // Bits needed for a counter running 0 .. limit-1.
   function automatic int cnt_width(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority picker; the first valid request
// at or after i_ptr (modulo NUM_REQ) wins.
module rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_any_valid
);

   logic [ID_W:0]   w_sum  [NUM_REQ];
   logic [ID_W-1:0] w_cand [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         assign w_sum[gi]  = {1'b0, i_ptr} + (ID_W+1)'(gi);
         assign w_cand[gi] = (w_sum[gi] >= (ID_W+1)'(NUM_REQ)) ?
                             ID_W'(w_sum[gi] - (ID_W+1)'(NUM_REQ)) : w_sum[gi][ID_W-1:0];
      end
   endgenerate

   // Scan from the farthest offset down so the nearest valid candidate wins.
   always_comb begin
      o_idx       = '0;
      o_any_valid = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (i_req[w_cand[k]]) begin
            o_idx       = w_cand[k];
            o_any_valid = 1'b1;
         end
      end
      o_grant = o_any_valid ? (NUM_REQ'(1) << o_idx) : '0;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART_TX among NUM_REQ producers.
// Define UART_ARB_WDOG_EN to add a busy-stuck watchdog in WAIT_DONE.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int NUM_REQ        = 4,
   parameter int BUSY_WAIT      = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_par_en,
   input  logic [NUM_REQ-1:0]            req_par_typ,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          tx_busy,
   output logic                          tx_data_valid,
   output logic [DATA_WIDTH-1:0]         tx_p_data,
   output logic                          tx_par_en,
   output logic                          tx_par_typ,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          arb_busy,
   output logic                          tx_err
);

   localparam int ID_W    = $clog2(NUM_REQ);
   // One counter serves both the busy-rise check and the watchdog.
   localparam int CNT_MAX = (TIMEOUT_CYCLES > BUSY_WAIT) ? TIMEOUT_CYCLES : BUSY_WAIT;
   localparam int CNT_W   = cnt_width(CNT_MAX);

   logic [1:0]            r_state;
   logic [ID_W-1:0]       r_ptr;
   logic [ID_W-1:0]       r_grant_id;
   logic [NUM_REQ-1:0]    r_grant_oh;
   logic [DATA_WIDTH-1:0] r_tx_p_data;
   logic                  r_tx_par_en;
   logic                  r_tx_par_typ;
   logic                  r_tx_err;
   logic [CNT_W-1:0]      r_cnt;

   logic [NUM_REQ-1:0]    w_grant_oh;
   logic [ID_W-1:0]       w_grant_idx;
   logic                  w_any_valid;
   logic [ID_W-1:0]       w_ptr_next;
   logic [DATA_WIDTH-1:0] w_req_byte [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_req_byte[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .i_req       (req_valid),
      .i_ptr       (r_ptr),
      .o_grant     (w_grant_oh),
      .o_idx       (w_grant_idx),
      .o_any_valid (w_any_valid)
   );

   assign w_ptr_next = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_grant_id   <= '0;
         r_grant_oh   <= '0;
         r_tx_p_data  <= '0;
         r_tx_par_en  <= 1'b0;
         r_tx_par_typ <= 1'b0;
         r_tx_err     <= 1'b0;
         r_cnt        <= '0;
      end else begin
         r_tx_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any_valid && !tx_busy) begin
                  r_grant_id   <= w_grant_idx;
                  r_grant_oh   <= w_grant_oh;
                  r_tx_p_data  <= w_req_byte[w_grant_idx];
                  r_tx_par_en  <= req_par_en[w_grant_idx];
                  r_tx_par_typ <= req_par_typ[w_grant_idx];
                  r_state      <= ST_START;
               end
            end
            ST_START: begin
               r_ptr   <= w_ptr_next;
               r_cnt   <= '0;
               r_state <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (tx_busy) begin
                  r_cnt   <= '0;
                  r_state <= ST_WAIT_DONE;
               end else if (r_cnt == CNT_W'(BUSY_WAIT - 1)) begin
                  r_tx_err <= 1'b1;
                  r_state  <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_WAIT_DONE: begin
`ifdef UART_ARB_WDOG_EN
               if (!tx_busy) begin
                  r_state <= ST_IDLE;
               end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  r_tx_err <= 1'b1;
                  r_state  <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
`else
               if (!tx_busy) begin
                  r_state <= ST_IDLE;
               end
`endif
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign tx_data_valid = (r_state == ST_START);
   assign req_ready     = tx_data_valid ? r_grant_oh : '0;
   assign arb_busy      = (r_state != ST_IDLE);
   assign tx_p_data     = r_tx_p_data;
   assign tx_par_en     = r_tx_par_en;
   assign tx_par_typ    = r_tx_par_typ;
   assign grant_id      = r_grant_id;
   assign tx_err        = r_tx_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized stimulus checked against a
// transaction-level model of round-robin arbitration and a UART_TX busy source.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int DW    = 8;
   localparam int NR    = 4;
   localparam int BW    = 4;
   localparam int TO    = 64;
   localparam int NEVER = 32'h3fff_ffff;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_par_en;
   logic [NR-1:0]     req_par_typ;
   logic [NR-1:0]     req_ready;
   logic              tx_busy;
   logic              tx_data_valid;
   logic [DW-1:0]     tx_p_data;
   logic              tx_par_en;
   logic              tx_par_typ;
   logic [1:0]        grant_id;
   logic              arb_busy;
   logic              tx_err;

   uart_tx_arbiter #(
      .DATA_WIDTH     (DW),
      .NUM_REQ        (NR),
      .BUSY_WAIT      (BW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_par_en    (req_par_en),
      .req_par_typ   (req_par_typ),
      .req_ready     (req_ready),
      .tx_busy       (tx_busy),
      .tx_data_valid (tx_data_valid),
      .tx_p_data     (tx_p_data),
      .tx_par_en     (tx_par_en),
      .tx_par_typ    (tx_par_typ),
      .grant_id      (grant_id),
      .arb_busy      (arb_busy),
      .tx_err        (tx_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Producers: one pending byte each; reload means "refill right after acceptance".
   bit         pend   [NR];
   logic [7:0] pdata  [NR];
   bit         ppen   [NR];
   bit         ptyp   [NR];
   bit         reload [NR];
   bit         rst_req   = 1'b1;
   bit         rand_drop = 1'b0;

   // UART_TX busy source: 0 normal frame, 1 never busy, 2 busy stuck high.
   int tx_mode    = 0;
   bit foreign    = 1'b0;
   int busy_from  = NEVER;
   int busy_until = NEVER;

   // Arbitration expectations.
   int         mptr       = 0;
   int         exp_pulse  = -1;
   int         exp_err    = -1;
   int         exp_idx    = 0;
   int         idle_at    = NEVER;
   bit         in_flight  = 1'b0;
   logic [9:0] exp_word   = '0;
   int         hold_from  = NEVER;
   int         hold_until = NEVER;
   int         last_pulse = -1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc %0d got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int pick(input logic [NR-1:0] vec, input int ptr);
      for (int k = 0; k < NR; k++) begin
         if (vec[(ptr + k) % NR]) return (ptr + k) % NR;
      end
      return -1;
   endfunction

   task automatic load(input int i, input logic [7:0] d, input bit pe, input bit pt);
      pend[i]  = 1'b1;
      pdata[i] = d;
      ppen[i]  = pe;
      ptyp[i]  = pt;
   endtask

   task automatic cycle();
      logic          exp_dv;
      logic [NR-1:0] exp_rdy;
      int            len;
      @(posedge clk);
      #1;
      cyc++;
      if (in_flight && cyc >= idle_at) in_flight = 1'b0;
      exp_dv  = (cyc == exp_pulse);
      exp_rdy = exp_dv ? (NR'(1) << exp_idx) : '0;
      check_val("pulse", {tx_data_valid, req_ready}, {exp_dv, exp_rdy});
      check_val("err", tx_err, cyc == exp_err);
      check_val("arb_busy", arb_busy, in_flight || exp_dv);
      if (reset) check_val("rst_zero", {grant_id, tx_par_typ, tx_par_en, tx_p_data}, 0);
      if (cyc >= hold_from && cyc < hold_until)
         check_val("hold", {tx_par_typ, tx_par_en, tx_p_data}, exp_word);
      if (exp_dv) begin
         check_val("grant_id", grant_id, exp_idx);
         check_val("data", {tx_par_typ, tx_par_en, tx_p_data}, exp_word);
         $display("grant cyc %0d id %0d data %02h par_en %0d par_typ %0d",
                  cyc, grant_id, tx_p_data, tx_par_en, tx_par_typ);
         in_flight  = 1'b1;
         idle_at    = NEVER;
         exp_pulse  = -1;
         last_pulse = cyc;
         mptr       = (exp_idx + 1) % NR;
         if (reload[exp_idx]) load(exp_idx, 8'($urandom), 1'($urandom), 1'($urandom));
         else                 pend[exp_idx] = 1'b0;
         case (tx_mode)
            0: begin
               len        = exp_word[8] ? 11 : 10;
               busy_from  = cyc + 1;
               busy_until = cyc + 1 + len;
               idle_at    = busy_until + 1;
               hold_from  = cyc + 1;
               hold_until = busy_until;
            end
            1: begin
               exp_err = cyc + 1 + BW;
               idle_at = exp_err;
            end
            default: begin
               busy_from  = cyc + 1;
               busy_until = NEVER;
               exp_err    = cyc + 2 + TO;
               idle_at    = exp_err;
            end
         endcase
      end

      if (rand_drop) begin
         for (int i = 0; i < NR; i++)
            if (pend[i] && !reload[i] && $urandom_range(39) == 0) pend[i] = 1'b0;
      end
      reset = rst_req;
      if (rst_req) begin
         mptr       = 0;
         exp_pulse  = -1;
         exp_err    = -1;
         in_flight  = 1'b0;
         idle_at    = NEVER;
         busy_from  = NEVER;
         busy_until = NEVER;
         hold_from  = NEVER;
         hold_until = NEVER;
      end
      tx_busy = foreign || (cyc >= busy_from && cyc < busy_until);
      for (int i = 0; i < NR; i++) begin
         req_valid[i]         = pend[i];
         req_data[i*DW +: DW] = pdata[i];
         req_par_en[i]        = ppen[i];
         req_par_typ[i]       = ptyp[i];
      end
      if (!reset && !in_flight && exp_pulse < 0 && req_valid != '0 && !tx_busy) begin
         exp_idx   = pick(req_valid, mptr);
         exp_pulse = cyc + 1;
         exp_word  = {ptyp[exp_idx], ppen[exp_idx], pdata[exp_idx]};
      end
   endtask

   initial begin
      int t0;
      int w;
      reset       = 1'b1;
      tx_busy     = 1'b0;
      req_valid   = '0;
      req_data    = '0;
      req_par_en  = '0;
      req_par_typ = '0;
      for (int i = 0; i < NR; i++) begin
         pend[i] = 1'b0; pdata[i] = '0; ppen[i] = 1'b0; ptyp[i] = 1'b0; reload[i] = 1'b0;
      end
      repeat (3) cycle();
      rst_req = 1'b0;

      // Single byte, no parity, 10-bit frame.
      load(0, 8'hD3, 1'b0, 1'b0);
      repeat (20) cycle();

      // All four at once from a fresh pointer.
      rst_req = 1'b1;
      repeat (2) cycle();
      rst_req = 1'b0;
      load(0, 8'h11, 1'b0, 1'b0);
      load(1, 8'h22, 1'b0, 1'b0);
      load(2, 8'h33, 1'b0, 1'b0);
      load(3, 8'h44, 1'b0, 1'b0);
      repeat (70) cycle();

      // Requesters 0 and 2 held continuously.
      reload[0] = 1'b1;
      reload[2] = 1'b1;
      load(0, 8'hA0, 1'b0, 1'b0);
      load(2, 8'hA2, 1'b1, 1'b0);
      repeat (80) cycle();
      reload[0] = 1'b0;
      reload[2] = 1'b0;
      repeat (40) cycle();

      // Odd parity, 11-bit frame.
      load(1, 8'hFB, 1'b1, 1'b1);
      repeat (20) cycle();

      // UART never goes busy: error after BUSY_WAIT, pointer still advances.
      tx_mode = 1;
      load(2, 8'h3C, 1'b0, 1'b0);
      repeat (8) cycle();
      tx_mode = 0;
      load(0, 8'h5E, 1'b0, 1'b1);
      load(3, 8'h7F, 1'b1, 1'b0);
      repeat (40) cycle();

      // Foreign frame on the UART while idle: no grant until it ends.
      foreign = 1'b1;
      load(1, 8'h66, 1'b0, 1'b0);
      repeat (6) cycle();
      foreign = 1'b0;
      repeat (20) cycle();

      // Reset mid-frame with requester 3 still waiting.
      rst_req = 1'b1;
      repeat (2) cycle();
      rst_req = 1'b0;
      load(1, 8'h5A, 1'b0, 1'b0);
      load(3, 8'hC4, 1'b1, 1'b0);
      t0 = cyc;
      w  = 0;
      while (last_pulse <= t0 && w < 40) begin
         cycle();
         w++;
      end
      check_val("t6_grant_seen", last_pulse > t0, 1);
      repeat (4) cycle();
      rst_req = 1'b1;
      repeat (2) cycle();
      rst_req = 1'b0;
      load(0, 8'h0F, 1'b0, 1'b0);
      repeat (40) cycle();

`ifdef UART_ARB_WDOG_EN
      // Busy stuck high: watchdog error, then the UART frees up.
      tx_mode = 2;
      load(2, 8'h99, 1'b0, 1'b0);
      repeat (TO + 10) cycle();
      tx_mode    = 0;
      busy_until = cyc + 1;
      repeat (10) cycle();
`endif

      // Randomized traffic with occasional forfeits.
      rand_drop = 1'b1;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (!pend[i] && $urandom_range(15) == 0)
               load(i, 8'($urandom), 1'($urandom), 1'($urandom));
         end
         cycle();
      end
      rand_drop = 1'b0;
      repeat (80) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
